// File: rtl/multi_button_debouncer_pkg.sv
// Shared defaults, counter-width helper and per-channel debounce state names
// for the multi-button debouncer.
package multi_button_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int DEFAULT_REPEAT_DELAY    = 50000000;
   localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } deb_state_e;

   // Bits needed to hold any value 0..max_val (at least 1).
   function automatic int clog2_cnt(input int max_val);
      int w;
      w = 1;
      while ((longint'(1) << w) <= longint'(max_val))
         w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/multi_button_debouncer_channel.sv
// One debounce channel: polarity normalise, 2-flop synchroniser, stability
// counter with level/press/release outputs; auto-repeat under MULTI_BUTTON_DEBOUNCER_REPEAT_EN.
module debounce_channel
   import multi_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int ACTIVE_HIGH     = 1
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
`endif
) (
   input  logic global_clock,
   input  logic reset,
   input  logic enable,
   input  logic button_pin,
   output logic button_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic repeat_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             raw;
   logic             sync_meta;
   logic             sync_q;
   logic [CNT_W-1:0] cnt;
   deb_state_e       state;

   assign raw = (ACTIVE_HIGH != 0) ? button_pin : ~button_pin;

   // The level is the upper state bit: PRESSED and RELEASE_PEND both mean "accepted pressed".
   assign button_level = (state == PRESSED) || (state == RELEASE_PEND);

   always_ff @(posedge global_clock or negedge reset) begin
      if (!reset) begin
         sync_meta     <= 1'b0;
         sync_q        <= 1'b0;
         state         <= RELEASED;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else if (!enable) begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_meta     <= raw;
         sync_q        <= sync_meta;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (sync_q) begin
                  state <= PRESS_PEND;
                  cnt   <= CNT_ONE;
               end
            end
            PRESS_PEND: begin
               if (!sync_q) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state       <= PRESSED;
                  cnt         <= '0;
                  press_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!sync_q) begin
                  state <= RELEASE_PEND;
                  cnt   <= CNT_ONE;
               end
            end
            RELEASE_PEND: begin
               if (sync_q) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state         <= RELEASED;
                  cnt           <= '0;
                  release_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
         endcase
      end
   end

`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = clog2_cnt(RPT_MAX);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic             rpt_first;

   // Counting starts the edge after press_pulse, so the first repeat can never overlap it.
   always_ff @(posedge global_clock or negedge reset) begin
      if (!reset) begin
         rpt_cnt      <= '0;
         rpt_first    <= 1'b1;
         repeat_pulse <= 1'b0;
      end else if (!enable || !button_level) begin
         rpt_cnt      <= '0;
         rpt_first    <= 1'b1;
         repeat_pulse <= 1'b0;
      end else if (rpt_cnt == (rpt_first ? DELAY_LAST : PERIOD_LAST)) begin
         rpt_cnt      <= '0;
         rpt_first    <= 1'b0;
         repeat_pulse <= 1'b1;
      end else begin
         rpt_cnt      <= rpt_cnt + RPT_W'(1);
         repeat_pulse <= 1'b0;
      end
   end
`else
   assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer top: one debounce_channel per pin plus a
// registered any_pressed. Auto-repeat is built only with MULTI_BUTTON_DEBOUNCER_REPEAT_EN.
module multi_button_debouncer
   import multi_button_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int ACTIVE_HIGH     = 1,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
   input  logic              global_clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [NUM_CH-1:0] button_in,
   output logic [NUM_CH-1:0] button_level,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic [NUM_CH-1:0] repeat_pulse,
   output logic              any_pressed
);

   if (NUM_CH < 1 || NUM_CH > 32 || DEBOUNCE_CYCLES < 2 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
      $error("multi_button_debouncer: parameter out of range");
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_HIGH     (ACTIVE_HIGH)
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .global_clock  (global_clock),
         .reset         (reset),
         .enable        (enable),
         .button_pin    (button_in[i]),
         .button_level  (button_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .repeat_pulse  (repeat_pulse[i])
      );
   end

   always_ff @(posedge global_clock or negedge reset) begin
      if (!reset) any_pressed <= 1'b0;
      else        any_pressed <= |button_level;
   end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Self-checking bench for multi_button_debouncer: directed scenarios plus random
// bouncing pins compared every cycle against a run-length reference model.
module tb_multi_button_debouncer;

   localparam int NUM_CH = 4;
   localparam int DC     = 8;
   localparam int RD     = 20;
   localparam int RP     = 5;
   localparam int W      = 4 * NUM_CH + 1;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [NUM_CH-1:0] pin;
   logic [NUM_CH-1:0] level, press, rel, rpt;
   logic              any;

   always #5 clk = ~clk;

   multi_button_debouncer #(
      .NUM_CH          (NUM_CH),
      .DEBOUNCE_CYCLES (DC),
      .ACTIVE_HIGH     (1),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .global_clock  (clk),
      .reset         (rst_n),
      .enable        (en),
      .button_in     (pin),
      .button_level  (level),
      .press_pulse   (press),
      .release_pulse (rel),
      .repeat_pulse  (rpt),
      .any_pressed   (any)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Each channel sees its pin two enabled edges late; a change is accepted once
   // DC consecutive enabled edges have compared a value different from the level.
   bit   m_s1  [NUM_CH];
   bit   m_s2  [NUM_CH];
   bit   m_lvl [NUM_CH];
   int   m_run [NUM_CH];
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
   int   m_next [NUM_CH];
`endif
   int   cyc = 0;
   logic [W-1:0] exp_q[$];

   always @(posedge clk) begin : model
      logic [NUM_CH-1:0] e_lvl, e_pr, e_rl, e_rp;
      logic              e_any;
      bit                cmp;
      cyc++;
      e_pr  = '0;
      e_rl  = '0;
      e_rp  = '0;
      e_any = 1'b0;
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) e_any |= m_lvl[c];
         for (int c = 0; c < NUM_CH; c++) begin
            if (en) begin
               cmp     = m_s2[c];
               m_s2[c] = m_s1[c];
               m_s1[c] = pin[c];
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
               if (m_lvl[c] && cyc == m_next[c]) begin
                  e_rp[c]   = 1'b1;
                  m_next[c] = cyc + RP;
               end
`endif
               if (cmp != m_lvl[c]) begin
                  m_run[c]++;
                  if (m_run[c] == DC) begin
                     m_lvl[c] = cmp;
                     m_run[c] = 0;
                     if (cmp) e_pr[c] = 1'b1;
                     else     e_rl[c] = 1'b1;
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
                     if (cmp) m_next[c] = cyc + RD;
`endif
                  end
               end else begin
                  m_run[c] = 0;
               end
            end else begin
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
               if (m_lvl[c]) m_next[c] = cyc + RD;
`endif
            end
         end
      end
      for (int c = 0; c < NUM_CH; c++) e_lvl[c] = m_lvl[c];
      exp_q.push_back({e_lvl, e_pr, e_rl, e_rp, e_any});
   end

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin : scoreboard
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!rst_n) e = '0;
         check("level",   32'(level), 32'(e[4*NUM_CH -: NUM_CH]));
         check("press",   32'(press), 32'(e[3*NUM_CH -: NUM_CH]));
         check("release", 32'(rel),   32'(e[2*NUM_CH -: NUM_CH]));
         check("repeat",  32'(rpt),   32'(e[NUM_CH -: NUM_CH]));
         check("any",     32'(any),   32'(e[0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_pulse(input int which, input int ch, input int max_cyc, output int lat);
      lat = -1;
      for (int k = 1; k <= max_cyc; k++) begin
         @(negedge clk);
         if ((which == 0 && press[ch]) || (which == 1 && rel[ch]) || (which == 2 && rpt[ch])) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int lat, npr, nrl, pos;
      bit pat [12];
      int rpt_pos[$];
      rst_n = 1'b0;
      en    = 1'b1;
      pin   = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // clean press on ch0
      pin[0] = 1'b1;
      wait_pulse(0, 0, 40, lat);
      check("clean_press_latency", 32'(lat), 32'd10);
      check("clean_press_level", 32'(level), 32'h1);
      @(negedge clk);
      check("clean_press_one_shot", 32'(press), 32'h0);

      // release with a one-cycle glitch
      npr = 0; nrl = 0; lat = -1;
      pin[0] = 1'b0;
      repeat (5) begin
         @(negedge clk); npr += int'(press[0]); nrl += int'(rel[0]);
      end
      pin[0] = 1'b1;
      @(negedge clk); npr += int'(press[0]); nrl += int'(rel[0]);
      pin[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk); npr += int'(press[0]); nrl += int'(rel[0]);
         if (rel[0] && lat < 0) lat = k;
      end
      check("release_latency", 32'(lat), 32'd10);
      check("release_count", 32'(nrl), 32'd1);
      check("release_no_press", 32'(npr), 32'd0);

      // bounce rejection on ch1
      pat = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
      npr = 0; pos = -1;
      for (int i = 0; i < 22; i++) begin
         pin[1] = (i < 12) ? pat[i] : 1'b1;
         @(negedge clk);
         if (press[1]) begin npr++; if (pos < 0) pos = i + 1; end
      end
      check("bounce_press_pos", 32'(pos), 32'd14);
      check("bounce_press_count", 32'(npr), 32'd1);
      pin[1] = 1'b0;
      repeat (14) @(negedge clk);

      // simultaneous press on ch2 and ch3
      pin[3:2] = 2'b11;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (press != '0) begin lat = k; break; end
      end
      check("simul_latency", 32'(lat), 32'd10);
      check("simul_press", 32'(press), 32'hc);
      check("simul_any_before", 32'(any), 32'h0);
      @(negedge clk);
      check("simul_any_after", 32'(any), 32'h1);

      // asynchronous reset in the middle of a count
      pin[1] = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("reset_level", 32'(level), 32'h0);
      check("reset_press", 32'(press), 32'h0);
      check("reset_any", 32'(any), 32'h0);
      repeat (2) @(negedge clk);
      pin   = '0;
      rst_n = 1'b1;
      @(negedge clk);

      // enable dropped with ch0 count at 4
      pin[0] = 1'b1;
      repeat (6) @(negedge clk);
      en  = 1'b0;
      npr = 0;
      repeat (10) begin @(negedge clk); npr += int'(press[0]); end
      check("disabled_no_press", 32'(npr), 32'd0);
      en = 1'b1;
      wait_pulse(0, 0, 20, lat);
      check("reenable_latency", 32'(lat), 32'd4);

      // auto-repeat while held
      pin[0] = 1'b0;
      repeat (14) @(negedge clk);
      pin[0] = 1'b1;
      wait_pulse(0, 0, 20, lat);
      check("repeat_press_latency", 32'(lat), 32'd10);
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (rpt[0]) rpt_pos.push_back(k);
      end
`ifdef MULTI_BUTTON_DEBOUNCER_REPEAT_EN
      check("repeat_count", 32'(rpt_pos.size()), 32'd3);
      for (int i = 0; i < 3 && i < rpt_pos.size(); i++)
         check("repeat_pos", 32'(rpt_pos[i]), 32'(RD + i * RP));
`else
      check("repeat_absent", 32'(rpt_pos.size()), 32'd0);
`endif
      pin[0] = 1'b0;
      repeat (15) @(negedge clk);

      // random bouncing pins with occasional enable drops
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(0, 11) == 0) pin[c] = ~pin[c];
         en = ($urandom_range(0, 19) != 0);
      end
      pin = '0;
      en  = 1'b1;
      repeat (20) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
